instr_loader: RTL and testbench

//   Writes a program into instruction memory from a byte stream, e.g. a UART receiver.

---
 rtl/instr_loader_pkg.sv | 23 ++
 rtl/instr_loader_word_pack.sv | 69 ++++++
 rtl/instr_loader.sv | 153 +++++++++++++++
 tb/tb_instr_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// instr_loader_pkg : state encoding and defaults shared by the image loader
// Revision 1.0
// ============================================================================
package instr_loader_pkg;

    localparam logic [2:0] ST_SYNC   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

    function automatic logic state_accepts(input logic [2:0] st);
        return (st != ST_DONE) && (st != ST_ERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_loader_word_pack.sv
`default_nettype none
// ============================================================================
// loader_word_pack : packs bytes little-endian into words, keeps running XOR
// Revision 1.0
// ============================================================================
module loader_word_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  idx_q,   idx_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  csum_q,  csum_d;
    logic        valid_q, valid_d;
    logic [31:0] word_q,  word_d;

    // Completed words are copied out of the shift register so the next byte
    // can be absorbed while the write strobe is still presenting this word.
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        csum_d  = csum_q;
        valid_d = 1'b0;
        word_d  = word_q;
        if (clear) begin
            idx_d   = 2'd0;
            shift_d = 32'd0;
            csum_d  = 8'd0;
        end else if (byte_en) begin
            shift_d = {byte_in, shift_q[31:8]};
            csum_d  = csum_q ^ byte_in;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                valid_d = 1'b1;
                word_d  = shift_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= 2'd0;
            shift_q <= 32'd0;
            csum_q  <= 8'd0;
            valid_q <= 1'b0;
            word_q  <= 32'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign word_done  = byte_en & ~clear & (idx_q == 2'd3);
    assign word_valid = valid_q;
    assign word       = word_q;
    assign csum       = csum_q;

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// instr_loader : loads a checksummed byte-stream image into instruction memory
// Revision 1.0
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         MAX_WORDS = 64,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    logic [2:0]        state_q,      state_d;
    logic [7:0]        len_lo_q,     len_lo_d;
    logic [CNT_W-1:0]  len_q,        len_d;
    logic [CNT_W-1:0]  wcnt_q,       wcnt_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic              rx_ready_q,   rx_ready_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;
    logic              core_rst_n_q, core_rst_n_d;

    logic        accept;
    logic [15:0] len_full;
    logic        pack_clear;
    logic        pack_en;
    logic        word_done;
    logic        word_valid;
    logic [31:0] word;
    logic [7:0]  csum;

    assign accept     = rx_valid & rx_ready_q;
    assign len_full   = {rx_data, len_lo_q};
    assign pack_clear = accept && (state_q == ST_SYNC);
    assign pack_en    = accept && (state_q == ST_DATA);

    loader_word_pack u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pack_clear),
        .byte_en    (pack_en),
        .byte_in    (rx_data),
        .word_done  (word_done),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        case (state_q)
            ST_SYNC: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if (len_full > 16'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d   = CNT_W'(len_full);
                        wcnt_d  = '0;
                        state_d = (len_full == 16'd0) ? ST_CSUM : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    addr_d = ADDR_W'({wcnt_q, 2'b00});
                    wcnt_d = wcnt_q + CNT_W'(1);
                    if ((wcnt_q + CNT_W'(1)) == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Status outputs are registered from the next state so they rise
        // in the cycle right after the deciding byte.
        rx_ready_d   = state_accepts(state_d);
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
        core_rst_n_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            len_lo_q     <= 8'd0;
            len_q        <= '0;
            wcnt_q       <= '0;
            addr_q       <= '0;
            rx_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            addr_q       <= addr_d;
            rx_ready_q   <= rx_ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = word_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = word;
    assign done       = done_q;
    assign err        = err_q;
    assign core_rst_n = core_rst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// tb_instr_loader : randomized stimulus against a byte-position reference model
// Revision 1.0
// ============================================================================
module tb_instr_loader;

    localparam int         ADDR_W = 8;
    localparam int         MAXW   = 64;
    localparam logic [7:0] SYNC   = 8'h55;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              done;
    logic              err;

    instr_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .SYNC_BYTE(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int we_count = 0;
    bit cmp_en = 1'b0;

    logic [31:0] dut_mem [64];
    logic [31:0] exp_mem [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the image rather than a state.
    bit          m_ready = 0, m_we = 0, m_done = 0, m_err = 0, m_hunt = 1, m_after_rst = 0;
    logic [7:0]  m_addr = 0;
    logic [31:0] m_wdata = 0;
    logic [7:0]  m_lo = 0, m_x = 0;
    logic [7:0]  m_bytes [4];
    int          m_pos = 0, m_len = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready = 0; m_we = 0; m_done = 0; m_err = 0; m_hunt = 1;
            m_addr = 0; m_wdata = 0; m_x = 0; m_pos = 0; m_after_rst = 1;
        end else begin
            m_we = 0;
            m_after_rst = 0;
            if (rx_valid && m_ready) begin
                if (m_hunt) begin
                    if (rx_data == SYNC) begin
                        m_hunt = 0; m_pos = 1; m_x = 0;
                    end
                end else if (m_pos == 1) begin
                    m_lo = rx_data; m_pos = 2;
                end else if (m_pos == 2) begin
                    m_len = int'({rx_data, m_lo});
                    if (m_len > MAXW) m_err = 1;
                    m_pos = 3;
                end else if (m_pos < 3 + 4 * m_len) begin
                    m_bytes[(m_pos - 3) % 4] = rx_data;
                    m_x = m_x ^ rx_data;
                    if ((m_pos - 3) % 4 == 3) begin
                        m_we    = 1;
                        m_addr  = 8'(4 * ((m_pos - 3) / 4));
                        m_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                        exp_mem[(m_pos - 3) / 4] = m_wdata;
                    end
                    m_pos++;
                end else begin
                    if (rx_data == m_x) m_done = 1;
                    else                m_err  = 1;
                end
            end
            m_ready = !(m_done || m_err);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("rx_ready", 32'(rx_ready), 32'(m_ready));
            check("imem_we", 32'(imem_we), 32'(m_we));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            check("core_rst_n", 32'(core_rst_n), 32'(m_done));
            if (m_we || m_after_rst) begin
                check("imem_addr", 32'(imem_addr), 32'(m_addr));
                check("imem_wdata", imem_wdata, m_wdata);
            end
            if (imem_we === 1'b1) begin
                dut_mem[imem_addr[ADDR_W-1:2]] = imem_wdata;
                we_count++;
            end
        end
    end

    task automatic do_reset();
        rx_valid = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        cmp_en = 1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        rx_valid = 0;
        repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        rx_data = b;
        rx_valid = 1;
        while (!m_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!m_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted byte=0x%0h", b);
            rx_valid = 0;
            return;
        end
        @(posedge clk); #1;
        rx_valid = 0;
        rx_data = 8'($urandom);
    endtask

    task automatic send_q(input logic [7:0] q[$], input int gap);
        foreach (q[i]) send(q[i], gap);
    endtask

    task automatic drive_junk(input int n);
        rx_valid = 1;
        repeat (n) begin rx_data = 8'($urandom); @(posedge clk); #1; end
        rx_valid = 0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 64; i++) check(tag, dut_mem[i], exp_mem[i]);
    endtask

    logic [7:0] img1 [$];
    logic [7:0] img [$];

    initial begin
        int len, wc;
        bit bad, exp_ok;
        logic [7:0] x, b;
        for (int i = 0; i < 64; i++) begin dut_mem[i] = 0; exp_mem[i] = 0; end
        // Data XOR is 13^93^10 = 90.
        img1 = '{8'h55, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};

        // Reset values and test 1
        rst_n = 0;
        @(posedge clk); #1;
        check("rst_rx_ready", 32'(rx_ready), 0);
        check("rst_core_rst_n", 32'(core_rst_n), 0);
        do_reset();
        send_q(img1, 0);
        check("c1_done_c+1", 32'(done), 1);
        check("c1_core_rst_n", 32'(core_rst_n), 1);
        repeat (2) begin @(posedge clk); #1; end
        check("c1_mem0_lit", dut_mem[0], 32'h0000_0013);
        check("c1_mem1_lit", dut_mem[1], 32'h0010_0093);
        check("c1_model_mem1_lit", exp_mem[1], 32'h0010_0093);
        drive_junk(4);
        check_mem("c1_mem");

        // Test 2: empty image
        do_reset();
        wc = we_count;
        send_q('{8'h55, 8'h00, 8'h00, 8'h00}, 0);
        check("c2_done_c+1", 32'(done), 1);
        check("c2_no_writes", 32'(we_count - wc), 0);

        // Test 3: length over the limit
        do_reset();
        send_q('{8'h55, 8'h41, 8'h00}, 0);
        check("c3_err", 32'(err), 1);
        check("c3_rx_ready", 32'(rx_ready), 0);
        check("c3_core_rst_n", 32'(core_rst_n), 0);
        drive_junk(3);

        // Test 4: bad checksum
        do_reset();
        img = img1;
        img[11] = 8'h80;
        wc = we_count;
        send_q(img, 0);
        check("c4_err", 32'(err), 1);
        check("c4_core_rst_n", 32'(core_rst_n), 0);
        check("c4_writes", 32'(we_count - wc), 2);

        // Test 5: junk prefix with gaps
        do_reset();
        send_q('{8'hAA, 8'h00}, 3);
        send_q(img1, 3);
        check("c5_done", 32'(done), 1);
        @(posedge clk); #1;
        check_mem("c5_mem");

        // Test 6: reset mid-word, then a full load
        do_reset();
        wc = we_count;
        send_q('{8'h55, 8'h02, 8'h00, 8'h13, 8'h00}, 0);
        do_reset();
        check("c6_no_partial_write", 32'(we_count - wc), 0);
        send_q(img1, 1);
        check("c6_done", 32'(done), 1);
        @(posedge clk); #1;
        check("c6_mem0_lit", dut_mem[0], 32'h0000_0013);
        check_mem("c6_mem");

        // Randomized images, including the length boundaries
        for (int it = 0; it < 10; it++) begin
            case (it)
                0: len = MAXW;
                1: len = MAXW + 1;
                2: len = 1;
                3: len = 16'hFFFF;
                default: len = $urandom_range(0, MAXW);
            endcase
            bad = (it > 3) && ($urandom_range(0, 3) == 0);
            exp_ok = (len <= MAXW) && !bad;
            do_reset();
            img = {};
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                img.push_back(b);
            end
            img.push_back(SYNC);
            img.push_back(8'(len));
            img.push_back(8'(len >> 8));
            if (len <= MAXW) begin
                x = 0;
                for (int i = 0; i < 4 * len; i++) begin
                    b = (i % 7 == 2) ? SYNC : 8'($urandom);
                    x = x ^ b;
                    img.push_back(b);
                end
                img.push_back(bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
            end
            send_q(img, (it % 2) * 3);
            check("rnd_done", 32'(done), 32'(exp_ok));
            check("rnd_err", 32'(err), 32'(!exp_ok));
            drive_junk(3);
            check_mem("rnd_mem");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
